// File: rtl/btn_pkg.sv
// Shared constants, direction codes and handshake FSM states for the
// button-to-move front end.
package btn_pkg;

   // Default parameter values (100 MHz ClkPort, 1 ms sample tick)
   localparam int N_BTN_DEF       = 4;
   localparam int TICK_DIV_DEF    = 100000;
   localparam int DB_TICKS_DEF    = 16;
   localparam int REPEAT_EN_DEF   = 0;
   localparam int REPEAT_DLY_DEF  = 400;
   localparam int REPEAT_RATE_DEF = 100;

   // Channel index of each move direction
   localparam int DIR_U = 0;
   localparam int DIR_D = 1;
   localparam int DIR_L = 2;
   localparam int DIR_R = 3;

   // Handshake FSM states
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // Larger of two integers, used to size the repeat counter
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_move_ctrl_if.sv
// Move request handshake towards the game FSM.
// Handshake: the master raises req with req_dir and holds both stable until
// it samples ack=1 on a rising ClkPort edge; req then drops for at least one
// cycle before the next request. ack is ignored while req=0.
interface btn_move_ctrl_if #(
   parameter int N_BTN = 4
);
   localparam int DW = $clog2(N_BTN);

   logic          req;
   logic          ack;
   logic [DW-1:0] req_dir;

   modport master (output req, output req_dir, input ack);
   modport slave  (input req, input req_dir, output ack);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-driven debounce counter,
// press detection and optional auto-repeat. move_ev pulses for one cycle
// per press or repeat event.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DB_TICKS    = DB_TICKS_DEF,
   parameter int REPEAT_EN   = REPEAT_EN_DEF,
   parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
   parameter int REPEAT_RATE = REPEAT_RATE_DEF
)(
   input  logic ClkPort,
   input  logic rst,
   input  logic tick,
   input  logic btn_raw,
   output logic level,
   output logic move_ev
);
   localparam int DW = $clog2(DB_TICKS + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);

   logic [1:0]    sync_q;
   logic [DW-1:0] db_cnt;
   logic          press_q;
   logic          rep_ev;
   logic          flip;

   // The sample that completes DB_TICKS disagreeing ticks flips the level
   assign flip = tick && (sync_q[1] != level) && (db_cnt == DB_LAST);

   // Two-flop synchroniser for the asynchronous button input
   always_ff @(posedge ClkPort or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], btn_raw};
   end

   // Debounce on the sample tick; press_q marks a 0->1 flip of the level
   always_ff @(posedge ClkPort or posedge rst) begin
      if (rst) begin
         db_cnt  <= '0;
         level   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         press_q <= flip && !level;
         if (tick) begin
            if (sync_q[1] == level) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               db_cnt <= '0;
               level  <= ~level;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end
   end

   generate
      if (REPEAT_EN != 0) begin : g_rep
         localparam int RW = $clog2(max2(REPEAT_DLY, REPEAT_RATE) + 1);
         localparam logic [RW-1:0] DLY  = RW'(REPEAT_DLY);
         localparam logic [RW-1:0] RATE = RW'(REPEAT_RATE);

         logic [RW-1:0] rep_cnt;
         logic [RW-1:0] rep_nxt;
         logic          rep_phase;  // 0: waiting for first repeat, 1: repeating
         logic          rep_q;

         assign rep_nxt = rep_cnt + 1'b1;

         // Count ticks while held; first event after DLY, then every RATE
         always_ff @(posedge ClkPort or posedge rst) begin
            if (rst) begin
               rep_cnt   <= '0;
               rep_phase <= 1'b0;
               rep_q     <= 1'b0;
            end else begin
               rep_q <= 1'b0;
               if (!level) begin
                  rep_cnt   <= '0;
                  rep_phase <= 1'b0;
               end else if (tick) begin
                  if (rep_nxt == (rep_phase ? RATE : DLY)) begin
                     rep_q     <= 1'b1;
                     rep_cnt   <= '0;
                     rep_phase <= 1'b1;
                  end else begin
                     rep_cnt <= rep_nxt;
                  end
               end
            end
         end

         assign rep_ev = rep_q;
      end else begin : g_norep
         assign rep_ev = 1'b0;
      end
   endgenerate

   assign move_ev = press_q | rep_ev;

endmodule

// File: rtl/btn_move_ctrl.sv
// Button-to-move front end: shared sample tick, N_BTN debounce channels,
// per-channel pending bits with sticky overrun, and a lowest-index-first
// req/ack handshake towards the game FSM.
module btn_move_ctrl
   import btn_pkg::*;
#(
   parameter int N_BTN       = N_BTN_DEF,
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int DB_TICKS    = DB_TICKS_DEF,
   parameter int REPEAT_EN   = REPEAT_EN_DEF,
   parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
   parameter int REPEAT_RATE = REPEAT_RATE_DEF
)(
   input  logic             ClkPort,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   btn_move_ctrl_if.master  bus,
   output logic [N_BTN-1:0] btn_level,
   output logic             overrun,
   output state_t           fsm_state
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(N_BTN);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [N_BTN-1:0] move_ev;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] clr;
   logic [DW-1:0]    sel;
   state_t           state, state_nxt;
   logic             req_q, req_nxt;
   logic [DW-1:0]    dir_q, dir_nxt;

   assign tick = (tick_cnt == TICK_LAST);

   // Free-running sample tick divider
   always_ff @(posedge ClkPort or posedge rst) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_ch
         btn_debounce_ch #(
            .DB_TICKS    (DB_TICKS),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE)
         ) u_ch (
            .ClkPort (ClkPort),
            .rst     (rst),
            .tick    (tick),
            .btn_raw (btn_raw[i]),
            .level   (btn_level[i]),
            .move_ev (move_ev[i])
         );
      end
   endgenerate

   // Pending bits: a new event beats a same-cycle clear; an event landing on
   // an already pending channel is dropped and flagged
   always_ff @(posedge ClkPort or posedge rst) begin
      if (rst) begin
         pending <= '0;
         overrun <= 1'b0;
      end else begin
         pending <= (pending & ~clr) | move_ev;
         if (|(move_ev & pending & ~clr)) overrun <= 1'b1;
      end
   end

   // Lowest set pending index wins
   always_comb begin
      sel = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pending[i]) sel = DW'(i);
      end
   end

   // Handshake FSM state and registered request outputs
   always_ff @(posedge ClkPort or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         req_q <= 1'b0;
         dir_q <= '0;
      end else begin
         state <= state_nxt;
         req_q <= req_nxt;
         dir_q <= dir_nxt;
      end
   end

   // Handshake FSM next state: issue from IDLE, hold in REQ until ack
   always_comb begin
      state_nxt = state;
      req_nxt   = req_q;
      dir_nxt   = dir_q;
      clr       = '0;
      case (state)
         IDLE: begin
            if (|pending) begin
               state_nxt = REQ;
               req_nxt   = 1'b1;
               dir_nxt   = sel;
               clr[sel]  = 1'b1;
            end
         end
         REQ: begin
            if (bus.ack) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
         end
      endcase
   end

   assign bus.req     = req_q;
   assign bus.req_dir = dir_q;
   assign fsm_state   = state;

endmodule
